// File: rtl/fft16_vector_sequencer.sv
// rtl/fft16_vector_sequencer.sv - 16-point FFT buffer and sequencer driving a 4-lane vector unit
//
// Loads 16 complex samples, runs four column ops (with twiddles) and four
// row ops (without), then unloads the result in transposed order.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   ifft                          direction, captured with sample 0
//   in_valid/in_ready, in_real/in_imag      sample load handshake and data
//   out_valid/out_ready, out_real/out_imag  result unload handshake and data
//   vec_start, vec_control        op request pulse, {ifft, apply_twiddle}
//   vec_input_*, vec_twiddle_*    registered operand and twiddle vectors
//   vec_output_*, vec_done        result vector and completion pulse
//   tw_addr, tw_real/tw_imag      twiddle table row select and row data
//   busy                          high whenever not loading
module fft16_vector_sequencer #(
    parameter int formatWidth = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ifft,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [formatWidth-1:0]     in_real,
    input  logic [formatWidth-1:0]     in_imag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [formatWidth-1:0]     out_real,
    output logic [formatWidth-1:0]     out_imag,
    output logic                       vec_start,
    output logic [1:0]                 vec_control,
    output logic [formatWidth*4-1:0]   vec_input_real,
    output logic [formatWidth*4-1:0]   vec_input_imag,
    output logic [formatWidth*4-1:0]   vec_twiddle_real,
    output logic [formatWidth*4-1:0]   vec_twiddle_imag,
    input  logic [formatWidth*4-1:0]   vec_output_real,
    input  logic [formatWidth*4-1:0]   vec_output_imag,
    input  logic                       vec_done,
    output logic [1:0]                 tw_addr,
    input  logic [formatWidth*4-1:0]   tw_real,
    input  logic [formatWidth*4-1:0]   tw_imag,
    output logic                       busy
);

    localparam int FW = formatWidth;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_S1_ISSUE,
        ST_S1_WAIT,
        ST_S2_ISSUE,
        ST_S2_WAIT,
        ST_UNLOAD
    } state_t;

    state_t state, state_nxt;

    logic [3:0] n_q;
    logic [3:0] m_q;
    logic [1:0] j_q;
    logic       ifft_q;

    logic [FW-1:0] mem_re [16];
    logic [FW-1:0] mem_im [16];

    logic          in_accept, out_accept;
    logic          done_s1, done_s2, wr_en;
    logic          issue_load, nxt_s2;
    logic [1:0]    nxt_j;
    logic [3:0]    wr_idx [4];
    logic [3:0]    rd_idx [4];
    logic [FW-1:0] op_re [4];
    logic [FW-1:0] op_im [4];
    logic [FW*4-1:0] op_pack_re, op_pack_im;

    assign in_ready   = (state == ST_LOAD) && !rst;
    assign out_valid  = (state == ST_UNLOAD);
    assign busy       = (state != ST_LOAD);
    assign in_accept  = in_valid && in_ready;
    assign out_accept = out_valid && out_ready;

    assign done_s1 = (state == ST_S1_WAIT) && vec_done;
    assign done_s2 = (state == ST_S2_WAIT) && vec_done;
    assign wr_en   = done_s1 || done_s2;

    // The next op's operands are captured on the same edge that enters the
    // ISSUE state, so they are valid for the whole ISSUE cycle.
    assign issue_load = (in_accept && (n_q == 4'd15)) ||
                        (wr_en && !(done_s2 && (j_q == 2'd3)));
    assign nxt_s2 = done_s2 || (done_s1 && (j_q == 2'd3));
    assign nxt_j  = wr_en ? (j_q + 2'd1) : 2'd0;

    // Unload order is the transpose of the buffer: index 4*(m%4)+m/4.
    assign out_real = mem_re[{m_q[1:0], m_q[3:2]}];
    assign out_imag = mem_im[{m_q[1:0], m_q[3:2]}];

    // Column ops touch mem[j+4*i], row ops touch mem[4*j+i].
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wr_idx[i] = done_s2 ? {j_q, 2'(i)} : {2'(i), j_q};
            rd_idx[i] = nxt_s2 ? {nxt_j, 2'(i)} : {2'(i), nxt_j};
        end
    end

    // The last column op writes mem[3] while the first row op reads it, so
    // operands forward from the result vector being written this cycle.
    always_comb begin
        op_pack_re = '0;
        op_pack_im = '0;
        for (int i = 0; i < 4; i++) begin
            op_re[i] = mem_re[rd_idx[i]];
            op_im[i] = mem_im[rd_idx[i]];
            for (int k = 0; k < 4; k++) begin
                if (wr_en && (wr_idx[k] == rd_idx[i])) begin
                    op_re[i] = vec_output_real[k*FW +: FW];
                    op_im[i] = vec_output_imag[k*FW +: FW];
                end
            end
            op_pack_re[i*FW +: FW] = op_re[i];
            op_pack_im[i*FW +: FW] = op_im[i];
        end
    end

    // The row select leads by one cycle on an issue edge so that the
    // combinational table row is ready to be captured with the operands.
    always_comb begin
        tw_addr = 2'd0;
        if (issue_load) begin
            tw_addr = nxt_s2 ? 2'd0 : nxt_j;
        end else if ((state == ST_S1_ISSUE) || (state == ST_S1_WAIT)) begin
            tw_addr = j_q;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:     if (in_accept && (n_q == 4'd15)) state_nxt = ST_S1_ISSUE;
            ST_S1_ISSUE: state_nxt = ST_S1_WAIT;
            ST_S1_WAIT:  if (vec_done) state_nxt = (j_q == 2'd3) ? ST_S2_ISSUE : ST_S1_ISSUE;
            ST_S2_ISSUE: state_nxt = ST_S2_WAIT;
            ST_S2_WAIT:  if (vec_done) state_nxt = (j_q == 2'd3) ? ST_UNLOAD : ST_S2_ISSUE;
            ST_UNLOAD:   if (out_accept && (m_q == 4'd15)) state_nxt = ST_LOAD;
            default:     state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_LOAD;
            n_q              <= 4'd0;
            m_q              <= 4'd0;
            j_q              <= 2'd0;
            ifft_q           <= 1'b0;
            vec_start        <= 1'b0;
            vec_control      <= 2'd0;
            vec_input_real   <= '0;
            vec_input_imag   <= '0;
            vec_twiddle_real <= '0;
            vec_twiddle_imag <= '0;
        end else begin
            state     <= state_nxt;
            vec_start <= issue_load;
            if (in_accept) begin
                n_q <= n_q + 4'd1;
                if (n_q == 4'd0) begin
                    ifft_q <= ifft;
                end
            end
            if (wr_en) begin
                j_q <= nxt_j;
            end
            if (out_accept) begin
                m_q <= m_q + 4'd1;
            end
            if (issue_load) begin
                vec_control      <= {ifft_q, !nxt_s2};
                vec_input_real   <= op_pack_re;
                vec_input_imag   <= op_pack_im;
                vec_twiddle_real <= tw_real;
                vec_twiddle_imag <= tw_imag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_accept) begin
            mem_re[n_q] <= in_real;
            mem_im[n_q] <= in_imag;
        end
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                mem_re[wr_idx[k]] <= vec_output_real[k*FW +: FW];
                mem_im[wr_idx[k]] <= vec_output_imag[k*FW +: FW];
            end
        end
    end

endmodule

// File: tb/tb_fft16_vector_sequencer.sv
// tb/tb_fft16_vector_sequencer.sv - directed self-checking bench for fft16_vector_sequencer
module tb_fft16_vector_sequencer;

    localparam int FW = 9;
    localparam int VW = FW * 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifft;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_real, in_imag;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] out_real, out_imag;
    logic          vec_start;
    logic [1:0]    vec_control;
    logic [VW-1:0] vec_input_real, vec_input_imag;
    logic [VW-1:0] vec_twiddle_real, vec_twiddle_imag;
    logic [VW-1:0] vec_output_real, vec_output_imag;
    logic          vec_done;
    logic [1:0]    tw_addr;
    logic [VW-1:0] tw_real, tw_imag;
    logic          busy;

    fft16_vector_sequencer #(.formatWidth(FW)) dut (
        .clk              (clk),
        .rst              (rst),
        .ifft             (ifft),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_real          (in_real),
        .in_imag          (in_imag),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_real         (out_real),
        .out_imag         (out_imag),
        .vec_start        (vec_start),
        .vec_control      (vec_control),
        .vec_input_real   (vec_input_real),
        .vec_input_imag   (vec_input_imag),
        .vec_twiddle_real (vec_twiddle_real),
        .vec_twiddle_imag (vec_twiddle_imag),
        .vec_output_real  (vec_output_real),
        .vec_output_imag  (vec_output_imag),
        .vec_done         (vec_done),
        .tw_addr          (tw_addr),
        .tw_real          (tw_real),
        .tw_imag          (tw_imag),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Twiddle table: arbitrary row-dependent constant.
    assign tw_real = {4{7'd0, tw_addr}};
    assign tw_imag = '0;

    // Pass-through vector unit: done 3 cycles after start; any other done
    // pulse presents all-ones data so a spurious buffer write is visible.
    int            cnt = 0;
    int            starts = 0;
    int            inj_issue_at = -1;
    logic          model_done = 1'b0;
    logic          issue_done = 1'b0;
    logic          inj_done;
    logic [VW-1:0] cap_r, cap_i;
    logic [1:0]    ctrl_log [64];
    logic [1:0]    twa_log  [64];
    logic [VW-1:0] in_log   [64];

    assign vec_done        = model_done | issue_done | inj_done;
    assign vec_output_real = model_done ? cap_r : '1;
    assign vec_output_imag = model_done ? cap_i : '1;

    always @(posedge clk) begin
        #1;
        model_done = 1'b0;
        issue_done = 1'b0;
        if (rst) begin
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) model_done = 1'b1;
            end
            if (vec_start) begin
                cap_r = vec_input_real;
                cap_i = vec_input_imag;
                cnt = 3;
                if (starts < 64) begin
                    ctrl_log[starts] = vec_control;
                    twa_log[starts]  = tw_addr;
                    in_log[starts]   = vec_input_real;
                end
                if (starts == inj_issue_at) issue_done = 1'b1;
                starts++;
            end
        end
    end

    int exp_seq [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

    task automatic load_frame(input bit ifft0, input bit flip, input int inj_at);
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (n == 0) check("load_in_ready", in_ready, 1);
            if (n == inj_at + 1) begin
                check("load_done_busy", busy, 0);
                check("load_done_ready", in_ready, 1);
            end
            in_valid = 1'b1;
            in_real  = FW'(n);
            in_imag  = '0;
            ifft     = (n == 0) ? ifft0 : (flip ? ~ifft0 : ifft0);
            inj_done = (n == inj_at);
        end
        @(negedge clk);
        in_valid = 1'b0;
        inj_done = 1'b0;
    endtask

    task automatic unload_frame(input int stall_m);
        int t = 0;
        while (!out_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("unload_start", out_valid, 1);
        for (int m = 0; m < 16; m++) begin
            if (m == stall_m) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_real", out_real, exp_seq[m]);
                    @(negedge clk);
                end
            end
            check("out_valid", out_valid, 1);
            check($sformatf("out_real[%0d]", m), out_real, exp_seq[m]);
            if (m == 0) check("out_imag", out_imag, 0);
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("unload_end_busy", busy, 0);
    endtask

    initial begin
        int b;
        logic [VW-1:0] lanes;
        rst = 1'b1; ifft = 1'b0; in_valid = 1'b0; in_real = '0; in_imag = '0;
        out_ready = 1'b0; inj_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_vec_start", vec_start, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_tw_addr", tw_addr, 0);
        check("rst_vec_control", vec_control, 0);
        check("rst_vec_input", vec_input_real, 0);
        check("rst_vec_twiddle", vec_twiddle_real, 0);
        rst = 1'b0;

        // Frame 1: forward, spurious done in LOAD and in first ISSUE, stall at m=3.
        b = starts;
        inj_issue_at = b;
        load_frame(1'b0, 1'b0, 5);
        unload_frame(3);
        check("f1_starts", starts - b, 8);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("f1_s1_ctrl[%0d]", k), ctrl_log[b+k], 2'b01);
            check($sformatf("f1_s1_tw[%0d]", k), twa_log[b+k], k);
            check($sformatf("f1_s2_ctrl[%0d]", k), ctrl_log[b+4+k], 2'b00);
        end
        check("f1_s2_tw", twa_log[b+5], 0);
        lanes = {9'd12, 9'd8, 9'd4, 9'd0};
        check("f1_op0_lanes", in_log[b], lanes);
        lanes = {9'd7, 9'd6, 9'd5, 9'd4};
        check("f1_s2op1_lanes", in_log[b+5], lanes);
        inj_issue_at = -1;

        // Frame 2: ifft=1 on sample 0, then 0 for the rest of the load.
        b = starts;
        load_frame(1'b1, 1'b1, -1);
        unload_frame(-1);
        check("f2_starts", starts - b, 8);
        for (int k = 0; k < 8; k++)
            check($sformatf("f2_ifft[%0d]", k), ctrl_log[b+k][1], 1);

        // Frame 3: reset during the wait of S1 op 2.
        b = starts;
        load_frame(1'b0, 1'b0, -1);
        begin
            int t = 0;
            while (starts < b + 3 && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("abort_reach_op2", starts - b, 3);
        end
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_vec_start", vec_start, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle_busy", busy, 0);
        check("abort_idle_ready", in_ready, 1);

        // Frame 4: fresh frame after the abort.
        b = starts;
        load_frame(1'b0, 1'b0, -1);
        unload_frame(-1);
        check("f4_starts", starts - b, 8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
